// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] Segments;

    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } IndividualSegments;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    function automatic Segments seg7_glyph(input logic [3:0] nibble);
        Segments g;
        g = '0;
        unique case (nibble)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot counter and digit index for the scan driver.
// Outputs describe the slot position that takes effect at the coming edge.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 2,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CW = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          run,
    output logic [IW-1:0] index,
    output logic          in_blank,
    output logic          frame_wrap
);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    // When not running, both restart from zero so a new scan opens on digit 0.
    always_comb begin
        cnt_d      = '0;
        idx_d      = '0;
        frame_wrap = 1'b0;
        if (run) begin
            if (cnt_q == CNT_MAX) begin
                idx_d      = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                frame_wrap = (idx_q == IDX_MAX);
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign index    = idx_d;
    assign in_blank = (32'(cnt_d) < 32'(BLANK_CYCLES));

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with blank guard, leading-zero
// blanking, per-digit decimal points and frame-aligned updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic                lz_blank,
    output logic [6:0]          segments,
    output logic                seg_dp,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam Segments SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW != 0}};

    if (CLK_DIV <= BLANK_CYCLES || CLK_DIV < 2) begin : g_bad_cfg
        $error("seg7_scan_driver: CLK_DIV must be >= 2 and exceed BLANK_CYCLES");
    end

    scan_state_t state_q;
    scan_state_t state_d;
    logic        fstart;
    logic        run;
    logic        wrap;
    logic        in_blank;
    logic [IW-1:0] idx;

    logic [4*DIGITS-1:0] pend_val_q;
    logic [DIGITS-1:0]   pend_dp_q;
    logic                pend_vld_q;
    logic [4*DIGITS-1:0] disp_val_q;
    logic [4*DIGITS-1:0] disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q;
    logic [DIGITS-1:0]   disp_dp_d;

    logic [DIGITS-1:0] lz_mask;
    logic              allz;
    logic [3:0]        nib;
    logic              active;
    Segments           seg_on;
    logic              dp_on;
    logic [DIGITS-1:0] dig_on;

    assign run = (state_q == SCAN) && enable;

    seg7_slot_timer #(
        .DIGITS       (DIGITS),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .index      (idx),
        .in_blank   (in_blank),
        .frame_wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fstart  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SCAN;
                    fstart  = 1'b1;
                end
            end
            SCAN: begin
                if (!enable) state_d = IDLE;
                else         fstart  = wrap;
            end
        endcase
    end

    // A load coinciding with a frame start bypasses the pending register.
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (fstart && load) begin
            disp_val_d = value;
            disp_dp_d  = dp;
        end else if (fstart && pend_vld_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
        end
    end

    always_comb begin
        lz_mask = '0;
        allz    = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            allz       = allz & (disp_val_d[4*i +: 4] == 4'h0);
            lz_mask[i] = allz;
        end
    end

    always_comb begin
        nib    = disp_val_d[{idx, 2'b00} +: 4];
        active = (state_d == SCAN) && !in_blank;
        seg_on = '0;
        dp_on  = 1'b0;
        dig_on = '0;
        if (active) begin
            seg_on = (lz_blank && lz_mask[idx]) ? '0 : seg7_glyph(nib);
            dp_on  = disp_dp_d[idx];
            dig_on = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            segments   <= SEG_OFF;
            seg_dp     <= SEG_OFF[0];
            digit_sel  <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp;
            end
            pend_vld_q <= fstart ? 1'b0 : (load | pend_vld_q);
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            segments   <= seg_on ^ SEG_OFF;
            seg_dp     <= dp_on ^ SEG_OFF[0];
            digit_sel  <= dig_on ^ DIG_OFF;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver, run with an
// active-high and an active-low instance side by side.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int CLK_DIV = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz_blank;

    logic [6:0] seg_a;
    logic       sdp_a;
    logic [3:0] dig_a;
    logic       fd_a;
    logic [6:0] seg_b;
    logic       sdp_b;
    logic [3:0] dig_b;
    logic       fd_b;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .value(value), .dp(dp), .lz_blank(lz_blank),
        .segments(seg_a), .seg_dp(sdp_a), .digit_sel(dig_a),
        .frame_done(fd_a)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .value(value), .dp(dp), .lz_blank(lz_blank),
        .segments(seg_b), .seg_dp(sdp_b), .digit_sel(dig_b),
        .frame_done(fd_b)
    );

    typedef struct {
        logic [6:0] seg;
        logic       sdp;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    logic [6:0]  frm_seg[4];
    logic [3:0]  frm_dp;
    logic [15:0] ld_val;
    logic [3:0]  ld_dp;

    task automatic chk(input string tag, input logic [6:0] obs,
                       input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] s, input logic d,
                            input logic [3:0] g, input logic f);
        exp_t e;
        e.seg = s;
        e.sdp = d;
        e.dig = g;
        e.fd  = f;
        sb.push_back(e);
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".seg"}, seg_a, e.seg);
            chk({tag, ".dp"}, {6'b0, sdp_a}, {6'b0, e.sdp});
            chk({tag, ".dig"}, {3'b0, dig_a}, {3'b0, e.dig});
            chk({tag, ".fd"}, {6'b0, fd_a}, {6'b0, e.fd});
            chk({tag, ".segL"}, seg_b, ~e.seg);
            chk({tag, ".dpL"}, {6'b0, sdp_b}, {6'b0, ~e.sdp});
            chk({tag, ".digL"}, {3'b0, dig_b}, {3'b0, ~e.dig});
            chk({tag, ".fdL"}, {6'b0, fd_b}, {6'b0, e.fd});
        end
    endtask

    task automatic set_frame(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] d);
        frm_seg[3] = s3;
        frm_seg[2] = s2;
        frm_seg[1] = s1;
        frm_seg[0] = s0;
        frm_dp     = d;
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            push_exp(7'h00, 1'b0, 4'h0, 1'b0);
            tick_check($sformatf("%s.%0d", tag, k));
        end
    endtask

    // k counts cycles from the edge that opens slot 0 of the frame.
    task automatic check_frame(input string tag, input bit first_fd,
                               input int ncyc, input int load_at);
        for (int k = 0; k < ncyc; k++) begin
            int s;
            int d;
            logic f;
            s = k % CLK_DIV;
            d = k / CLK_DIV;
            f = (k == 0) && first_fd;
            if (s < BLANK) push_exp(7'h00, 1'b0, 4'h0, f);
            else push_exp(frm_seg[d], frm_dp[d], 4'(1 << d), f);
            tick_check($sformatf("%s.d%0d.c%0d", tag, d, s));
            load = 1'b0;
            if (k == load_at) begin
                load  = 1'b1;
                value = ld_val;
                dp    = ld_dp;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp       = 4'h0;
        lz_blank = 1'b0;
        ld_val   = 16'h0;
        ld_dp    = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 2);

        reset_n = 1'b1;
        check_idle("idle", 2);

        enable = 1'b1;
        set_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        check_frame("fA", 1'b0, 32, -1);

        ld_val = 16'h1A3F;
        ld_dp  = 4'b0100;
        check_frame("fB", 1'b1, 32, 12);

        set_frame(7'h06, 7'h77, 7'h4F, 7'h71, 4'b0100);
        ld_val = 16'h0005;
        ld_dp  = 4'b0000;
        check_frame("fC", 1'b1, 32, 20);

        lz_blank = 1'b1;
        set_frame(7'h00, 7'h00, 7'h00, 7'h6D, 4'b0000);
        ld_val = 16'h0000;
        ld_dp  = 4'b1000;
        check_frame("fD", 1'b1, 32, 20);

        set_frame(7'h00, 7'h00, 7'h00, 7'h3F, 4'b1000);
        ld_val = 16'h2222;
        ld_dp  = 4'b0000;
        check_frame("fE", 1'b1, 32, 31);

        set_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000);
        check_frame("fF", 1'b1, 32, -1);

        check_frame("fG", 1'b1, 22, -1);
        enable = 1'b0;
        check_idle("off", 4);

        enable = 1'b1;
        ld_val = 16'h7777;
        ld_dp  = 4'b1111;
        check_frame("fH", 1'b0, 10, 5);

        reset_n = 1'b0;
        check_idle("rstmid", 2);

        reset_n  = 1'b1;
        lz_blank = 1'b0;
        set_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        check_frame("fI", 1'b0, 32, -1);
        check_frame("fJ", 1'b1, 8, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
